affine_filter_acc_8: RTL

- Downstream stage of the eight per-tap MCM blocks (t0..t7) in the 8-bit affine 1/16-precision interpolation filter.
- Takes the eight phase-selected tap products for one output sample, sums them in a pipelined adder tree, rounds, shifts and clips to an 8-bit sample.
- Phase 0 (integer position) bypasses the filter and forwards the centre sample.
- Valid/ready on both sides; saturating count of clipped outputs for characterisation.

---
 rtl/affine_filter_acc_8_if.sv | 25 ++
 rtl/affine_filter_acc_8.sv | 110 +++++++++++
 2 files changed

// File: rtl/affine_filter_acc_8_if.sv
// Handshake bundle between the per-tap MCM blocks, the accumulation stage and
// the downstream sample consumer.
interface affine_filter_acc_8_if #(
  parameter int PW = 14,
  parameter int OW = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           frac;
  logic signed [OW-1:0] x_center;
  logic signed [PW-1:0] p0, p1, p2, p3, p4, p5, p6, p7;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] y;

  modport master (
    output in_valid, frac, x_center, p0, p1, p2, p3, p4, p5, p6, p7, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, frac, x_center, p0, p1, p2, p3, p4, p5, p6, p7, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/affine_filter_acc_8.sv
// Final stage of the 8-tap affine interpolation filter: pipelined adder tree,
// round/shift/clip to an OW-bit sample, frac==0 bypass and a clip counter.
module affine_filter_acc_8 #(
  parameter int PW    = 14,
  parameter int OW    = 8,
  parameter int SHIFT = 6,
  parameter int CW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  affine_filter_acc_8_if.slave bus,
  output logic [CW-1:0]        clip_cnt
);
  localparam int SW = PW + 3;
  localparam int RW = PW + 4;
  localparam logic signed [RW-1:0] HALF = RW'(2 ** (SHIFT - 1));
  localparam logic signed [RW-1:0] YMAX = RW'((2 ** (OW - 1)) - 1);
  localparam logic signed [RW-1:0] YMIN = RW'(-(2 ** (OW - 1)));

  // One extra bit so the rounding offset cannot overflow the full-scale sum.
  function automatic logic signed [RW-1:0] round_shift(input logic signed [SW-1:0] s);
    logic signed [RW-1:0] t;
    t = $signed({s[SW-1], s}) + HALF;
    return t >>> SHIFT;
  endfunction

  function automatic logic is_clipped(input logic signed [RW-1:0] r);
    return (r > YMAX) || (r < YMIN);
  endfunction

  function automatic logic signed [OW-1:0] saturate(input logic signed [RW-1:0] r);
    if (r > YMAX) return YMAX[OW-1:0];
    if (r < YMIN) return YMIN[OW-1:0];
    return r[OW-1:0];
  endfunction

  logic                 en;
  logic                 vld_p0, vld_p1, vld_p2;
  logic                 byp_p0, byp_p1;
  logic signed [OW-1:0] xc_p0, xc_p1;
  logic signed [PW:0]   a_p0 [4];
  logic signed [PW+1:0] b_p1 [2];
  logic signed [OW-1:0] y_p2;
  logic                 clip_p2;
  logic signed [SW-1:0] s_sum;
  logic signed [RW-1:0] r_rnd;
  logic signed [OW-1:0] y_next;
  logic                 clip_next;

  assign en            = !vld_p2 || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_p2;
  assign bus.y         = y_p2;

  // Stage p0: pair sums of the tap products
  always_ff @(posedge clk) begin
    if (en) begin
      byp_p0  <= (bus.frac == 4'd0);
      xc_p0   <= bus.x_center;
      a_p0[0] <= $signed({bus.p0[PW-1], bus.p0}) + $signed({bus.p1[PW-1], bus.p1});
      a_p0[1] <= $signed({bus.p2[PW-1], bus.p2}) + $signed({bus.p3[PW-1], bus.p3});
      a_p0[2] <= $signed({bus.p4[PW-1], bus.p4}) + $signed({bus.p5[PW-1], bus.p5});
      a_p0[3] <= $signed({bus.p6[PW-1], bus.p6}) + $signed({bus.p7[PW-1], bus.p7});
    end
  end

  // Stage p1: quad sums
  always_ff @(posedge clk) begin
    if (en) begin
      byp_p1  <= byp_p0;
      xc_p1   <= xc_p0;
      b_p1[0] <= $signed({a_p0[0][PW], a_p0[0]}) + $signed({a_p0[1][PW], a_p0[1]});
      b_p1[1] <= $signed({a_p0[2][PW], a_p0[2]}) + $signed({a_p0[3][PW], a_p0[3]});
    end
  end

  // Stage p2: final sum, round, clip or bypass into the output register
  always_comb begin
    s_sum     = $signed({b_p1[0][PW+1], b_p1[0]}) + $signed({b_p1[1][PW+1], b_p1[1]});
    r_rnd     = round_shift(s_sum);
    y_next    = byp_p1 ? xc_p1 : saturate(r_rnd);
    clip_next = !byp_p1 && is_clipped(r_rnd);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      clip_p2 <= clip_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      y_p2     <= '0;
      clip_cnt <= '0;
    end else begin
      if (vld_p2 && bus.out_ready && clip_p2 && (clip_cnt != '1)) begin
        clip_cnt <= clip_cnt + CW'(1);
      end
      if (en) begin
        vld_p0 <= bus.in_valid;
        vld_p1 <= vld_p0;
        vld_p2 <= vld_p1;
        y_p2   <= y_next;
      end
    end
  end
endmodule
